// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream clients, granting ownership
// round-robin per locked session, with a watchdog that reclaims the UART from an idle owner.
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   cli_lock,
  input  logic [N_REQ-1:0]   cli_tx_start,
  input  logic [8*N_REQ-1:0] cli_tx_data,
  output logic [N_REQ-1:0]   cli_tx_busy,
  input  logic               uart_tx_busy,
  output logic               uart_tx_start,
  output logic [7:0]         uart_tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         sess_bytes,
  output logic               timeout_pulse,
  output logic [1:0]         dbg_state
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [OW-1:0] RR_INIT   = OW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_OWN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       sess_bytes_q, sess_bytes_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             busy_prev_q, busy_prev_d;

  logic [N_REQ-1:0] req;
  logic [OW-1:0]    pick;
  logic [OW-1:0]    scan_w;
  logic             pick_vld;
  int               scan_idx;
  logic             own;
  logic             owner_start;
  logic             owner_lock;

  assign req         = cli_lock | cli_tx_start;
  assign own         = (state_q == S_OWN);
  assign owner_start = cli_tx_start[owner_q];
  assign owner_lock  = cli_lock[owner_q];

  // Scan starts just after the last owner, so it ends up with the lowest priority.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = 0;
    scan_w   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % N_REQ;
      scan_w   = OW'(scan_idx);
      if (!pick_vld && req[scan_w]) begin
        pick     = scan_w;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    cli_tx_busy   = '0;
    uart_tx_start = 1'b0;
    uart_tx_data  = 8'h00;
    if (own) begin
      uart_tx_start        = owner_start;
      uart_tx_data         = cli_tx_data[{owner_q, 3'b000} +: 8];
      cli_tx_busy[owner_q] = uart_tx_busy;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    sess_bytes_d    = sess_bytes_q;
    timeout_pulse_d = 1'b0;
    idle_cnt_d      = idle_cnt_q;
    busy_prev_d     = uart_tx_busy;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          sess_bytes_d  = 8'd0;
          idle_cnt_d    = '0;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: state_d = S_OWN;
      S_OWN: begin
        if (uart_tx_busy && !busy_prev_q && (sess_bytes_q != 8'hFF)) begin
          sess_bytes_d = sess_bytes_q + 8'd1;
        end
        if (owner_start || uart_tx_busy) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
        // Release only with busy low so a byte in flight is never cut.
        if (!owner_lock && !owner_start && !uart_tx_busy) begin
          state_d = S_RELEASE;
        end else if ((TIMEOUT_CYC != 0) && (idle_cnt_q == IDLE_LAST) && !uart_tx_busy) begin
          timeout_pulse_d = 1'b1;
          state_d         = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = owner_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      owner_q         <= '0;
      rr_ptr_q        <= RR_INIT;
      grant_q         <= '0;
      sess_bytes_q    <= 8'd0;
      timeout_pulse_q <= 1'b0;
      idle_cnt_q      <= '0;
      busy_prev_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      sess_bytes_q    <= sess_bytes_d;
      timeout_pulse_q <= timeout_pulse_d;
      idle_cnt_q      <= idle_cnt_d;
      busy_prev_q     <= busy_prev_d;
    end
  end

  assign grant         = grant_q;
  assign sess_bytes    = sess_bytes_q;
  assign timeout_pulse = timeout_pulse_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed client sessions, a behavioural UART, and a scoreboard
// of {grant, byte} pairs checked whenever the UART accepts a byte.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  // Handshake: a client holds cli_tx_start until its cli_tx_busy rises; the UART accepts
  // a byte on a clock edge where uart_tx_start=1 and uart_tx_busy=0.

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   cli_lock = '0;
  logic [N-1:0]   cli_tx_start = '0;
  logic [8*N-1:0] cli_tx_data = 24'h414243;
  logic [N-1:0]   cli_tx_busy;
  logic           uart_tx_busy = 1'b0;
  logic           uart_tx_start;
  logic [7:0]     uart_tx_data;
  logic [N-1:0]   grant;
  logic [7:0]     sess_bytes;
  logic           timeout_pulse;
  logic [1:0]     dbg_state;

  int          total = 0;
  int          bad = 0;
  int          uart_cnt = 0;
  logic [15:0] exp_q[$];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_lock(cli_lock), .cli_tx_start(cli_tx_start), .cli_tx_data(cli_tx_data),
    .cli_tx_busy(cli_tx_busy), .uart_tx_busy(uart_tx_busy),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .grant(grant), .sess_bytes(sess_bytes), .timeout_pulse(timeout_pulse),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // behavioural UART: busy for 4 cycles per accepted byte
  always @(posedge clk) begin
    if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_tx_busy <= 1'b0;
    end else if (uart_tx_start && !uart_tx_busy) begin
      uart_tx_busy <= 1'b1;
      uart_cnt     <= 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst_n && uart_tx_start && !uart_tx_busy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got grant=%0b data=%0h expected none", grant, uart_tx_data);
      end else begin
        e = exp_q.pop_front();
        check("uart_byte", {16'h0, 5'b0, grant, uart_tx_data}, {16'h0, e});
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic [N-1:0] g, input logic [7:0] d);
    exp_q.push_back({5'b0, g, d});
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string name);
    int k;
    k = 0;
    while (grant !== g && k < 100) begin
      tick();
      k++;
    end
    check(name, {29'h0, grant}, {29'h0, g});
  endtask

  task automatic send_byte(input int c, input logic [7:0] d);
    int k;
    cli_tx_data[c*8 +: 8] = d;
    cli_tx_start[c] = 1'b1;
    k = 0;
    while (!cli_tx_busy[c] && k < 300) begin
      tick();
      k++;
    end
    if (!cli_tx_busy[c]) begin
      total++;
      bad++;
      $display("FAIL send_busy_wait: client %0d got busy=0 expected 1", c);
    end
    cli_tx_start[c] = 1'b0;
    k = 0;
    while (cli_tx_busy[c] && k < 300) begin
      tick();
      k++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick(3);
    check("rst_grant", {29'h0, grant}, 32'h0);
    check("rst_sess_bytes", {24'h0, sess_bytes}, 32'h0);
    check("rst_timeout_pulse", {31'h0, timeout_pulse}, 32'h0);
    check("rst_uart_start", {31'h0, uart_tx_start}, 32'h0);
    check("rst_uart_data", {24'h0, uart_tx_data}, 32'h0);
    check("rst_cli_busy", {29'h0, cli_tx_busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: client1 sends A, B, C in one session
    expect_byte(3'b010, 8'h41);
    expect_byte(3'b010, 8'h42);
    expect_byte(3'b010, 8'h43);
    cli_lock[1] = 1'b1;
    check("t1_grant_before_edge", {29'h0, grant}, 32'h0);
    tick();
    check("t1_grant", {29'h0, grant}, 32'h2);
    send_byte(1, 8'h41);
    send_byte(1, 8'h42);
    send_byte(1, 8'h43);
    cli_lock[1] = 1'b0;
    wait_grant(3'b000, "t1_release");
    check("t1_sess_bytes", {24'h0, sess_bytes}, 32'd3);

    // 2: clients 0 and 2 lock together after client1's session
    expect_byte(3'b001, 8'h10);
    expect_byte(3'b001, 8'h11);
    expect_byte(3'b100, 8'h20);
    expect_byte(3'b100, 8'h21);
    cli_lock[0] = 1'b1;
    cli_lock[2] = 1'b1;
    wait_grant(3'b001, "t2_grant0");
    send_byte(0, 8'h10);
    send_byte(0, 8'h11);
    cli_lock[0] = 1'b0;
    wait_grant(3'b100, "t2_grant2");
    send_byte(2, 8'h20);
    send_byte(2, 8'h21);
    cli_lock[2] = 1'b0;
    wait_grant(3'b000, "t2_release");
    check("t2_sess_bytes", {24'h0, sess_bytes}, 32'd2);

    // 3: client0 back-to-back while client1 waits
    expect_byte(3'b001, 8'h30);
    expect_byte(3'b010, 8'h31);
    expect_byte(3'b001, 8'h32);
    cli_lock[0] = 1'b1;
    cli_lock[1] = 1'b1;
    wait_grant(3'b001, "t3_grant0");
    send_byte(0, 8'h30);
    cli_lock[0] = 1'b0;
    wait_grant(3'b000, "t3_gap");
    cli_lock[0] = 1'b1;
    tick();
    check("t3_grant1_first", {29'h0, grant}, 32'h2);
    send_byte(1, 8'h31);
    cli_lock[1] = 1'b0;
    wait_grant(3'b001, "t3_grant0_again");
    send_byte(0, 8'h32);
    cli_lock[0] = 1'b0;
    wait_grant(3'b000, "t3_release");

    // 5: non-owner raises start during client2's session
    expect_byte(3'b100, 8'h50);
    expect_byte(3'b100, 8'h51);
    expect_byte(3'b001, 8'h55);
    cli_lock[2] = 1'b1;
    wait_grant(3'b100, "t5_grant2");
    fork
      begin
        send_byte(2, 8'h50);
        send_byte(2, 8'h51);
        cli_lock[2] = 1'b0;
      end
      begin
        send_byte_stalled_check();
      end
    join
    wait_grant(3'b000, "t5_release");
    check("t5_sess_bytes", {24'h0, sess_bytes}, 32'd1);

    // 4: watchdog on an owner that locks but never sends
    cli_lock[1] = 1'b1;
    wait_grant(3'b010, "t4_grant");
    tick(16);
    check("t4_no_pulse_early", {31'h0, timeout_pulse}, 32'h0);
    tick();
    check("t4_pulse", {31'h0, timeout_pulse}, 32'h1);
    check("t4_grant_during_pulse", {29'h0, grant}, 32'h2);
    tick();
    check("t4_pulse_one_cycle", {31'h0, timeout_pulse}, 32'h0);
    check("t4_grant_dropped", {29'h0, grant}, 32'h0);
    wait_grant(3'b010, "t4_regrant");
    cli_lock[1] = 1'b0;
    wait_grant(3'b000, "t4_normal_release");
    check("t4_no_pulse_normal", {31'h0, timeout_pulse}, 32'h0);
    check("t4_sess_bytes", {24'h0, sess_bytes}, 32'd0);

    // 6: asynchronous reset mid-byte
    expect_byte(3'b001, 8'h66);
    cli_lock[0] = 1'b1;
    wait_grant(3'b001, "t6_grant");
    cli_tx_data[7:0] = 8'h66;
    cli_tx_start[0] = 1'b1;
    for (int k = 0; k < 50 && !cli_tx_busy[0]; k++) tick();
    tick();
    check("t6_pre_sess_bytes", {24'h0, sess_bytes}, 32'd1);
    check("t6_pre_uart_start", {31'h0, uart_tx_start}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", {29'h0, grant}, 32'h0);
    check("t6_rst_uart_start", {31'h0, uart_tx_start}, 32'h0);
    check("t6_rst_sess_bytes", {24'h0, sess_bytes}, 32'h0);
    cli_tx_start[0] = 1'b0;
    cli_lock[0] = 1'b0;
    tick(6);
    rst_n = 1'b1;
    tick(2);
    check("t6_after_rst_grant", {29'h0, grant}, 32'h0);

    check("exp_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // client0 raises start while client2 owns; its busy must stay low until it is granted
  task automatic send_byte_stalled_check();
    int k;
    cli_tx_data[7:0] = 8'h55;
    cli_tx_start[0] = 1'b1;
    tick(3);
    check("t5_nonowner_busy", {29'h0, cli_tx_busy}, 32'h4);
    check("t5_start_isolated", {31'h0, uart_tx_start}, 32'h0);
    k = 0;
    while (!cli_tx_busy[0] && k < 300) begin
      tick();
      k++;
    end
    check("t5_nonowner_served", {31'h0, cli_tx_busy[0]}, 32'h1);
    cli_tx_start[0] = 1'b0;
    k = 0;
    while (cli_tx_busy[0] && k < 300) begin
      tick();
      k++;
    end
  endtask

endmodule
